// File: rtl/i2c_cfg_sequencer.sv
// Walks an external ROM of {dev_addr, reg_addr, wdata} writes through an I2C master, with retry and pass/fail report.
// Optional write-then-read verification of each entry is enabled by defining I2C_CFG_READBACK_EN.
module i2c_cfg_sequencer #(
    parameter int TABLE_DEPTH    = 16,
    parameter int IDX_W          = 4,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 2000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [23:0]      tbl_data,
    output logic             m_start,
    output logic             m_wr,
    output logic [23:0]      m_data,
    input  logic             m_busy,
    input  logic             m_done,
    input  logic             m_error,
    input  logic [7:0]       m_rdata,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_fail,
    output logic [IDX_W-1:0] fail_idx,
    output logic             fail_timeout
);

    // Index is one bit wider than the ROM address so it can reach TABLE_DEPTH without wrapping.
    localparam int IDXC_W = IDX_W + 1;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_W, S_CHECK, S_ISSUE,
        S_WAIT, S_RELEASE, S_GAP, S_FINISH, S_FAIL
    } state_t;

    typedef enum logic [1:0] {OC_OK, OC_NACK, OC_TIMEOUT} outcome_t;

    state_t              state;
    outcome_t            outcome;
    logic [IDXC_W-1:0]   idx;
    logic [23:0]         entry;
    logic [RTY_W-1:0]    rty;
    logic [GAP_W-1:0]    gcnt;
    logic [TO_W-1:0]     tcnt;
    logic                go_q;
    logic                go_rise;

`ifdef I2C_CFG_READBACK_EN
    logic                rd_phase;
`else
    logic                rdata_unused;
    assign rdata_unused = ^m_rdata;
`endif

    assign go_rise  = go & ~go_q;
    assign tbl_addr = idx[IDX_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            outcome      <= OC_OK;
            idx          <= '0;
            entry        <= '0;
            rty          <= '0;
            gcnt         <= '0;
            tcnt         <= '0;
            go_q         <= 1'b0;
            m_start      <= 1'b0;
            m_wr         <= 1'b0;
            m_data       <= '0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_fail     <= 1'b0;
            fail_idx     <= '0;
            fail_timeout <= 1'b0;
`ifdef I2C_CFG_READBACK_EN
            rd_phase     <= 1'b0;
`endif
        end else begin
            go_q     <= go;
            cfg_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go_rise) begin
                        cfg_fail     <= 1'b0;
                        fail_idx     <= '0;
                        fail_timeout <= 1'b0;
                        idx          <= '0;
                        rty          <= '0;
                        cfg_busy     <= 1'b1;
                        m_wr         <= 1'b1;
`ifdef I2C_CFG_READBACK_EN
                        rd_phase     <= 1'b0;
`endif
                        state        <= S_FETCH;
                    end
                end
                S_FETCH:   state <= S_FETCH_W;
                S_FETCH_W: begin
                    entry <= tbl_data;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (entry == 24'hFFFFFF || int'(idx) == TABLE_DEPTH)
                        state <= S_FINISH;
                    else
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!m_busy) begin
                        m_data  <= entry;
`ifdef I2C_CFG_READBACK_EN
                        m_wr    <= ~rd_phase;
`else
                        m_wr    <= 1'b1;
`endif
                        m_start <= 1'b1;
                        tcnt    <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_done) begin
`ifdef I2C_CFG_READBACK_EN
                        // A readback that returns the wrong byte is retried exactly like a NACK.
                        outcome <= (!rd_phase || m_rdata == entry[7:0]) ? OC_OK : OC_NACK;
`else
                        outcome <= OC_OK;
`endif
                        m_start <= 1'b0;
                        state   <= S_RELEASE;
                    end else if (m_error) begin
                        outcome <= OC_NACK;
                        m_start <= 1'b0;
                        state   <= S_RELEASE;
                    end else if (int'(tcnt) == TIMEOUT_CYCLES - 1) begin
                        outcome <= OC_TIMEOUT;
                        m_start <= 1'b0;
                        state   <= S_RELEASE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (outcome == OC_TIMEOUT) begin
                        state <= S_FAIL;
                    end else if (!m_done && !m_error && !m_busy) begin
                        gcnt  <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (int'(gcnt) >= GAP_CYCLES - 1) begin
                        if (outcome == OC_OK) begin
`ifdef I2C_CFG_READBACK_EN
                            if (!rd_phase) begin
                                rd_phase <= 1'b1;
                                state    <= S_ISSUE;
                            end else begin
                                rd_phase <= 1'b0;
                                idx      <= idx + IDXC_W'(1);
                                rty      <= '0;
                                state    <= S_FETCH;
                            end
`else
                            idx   <= idx + IDXC_W'(1);
                            rty   <= '0;
                            state <= S_FETCH;
`endif
                        end else if (int'(rty) < MAX_RETRY) begin
                            rty   <= rty + RTY_W'(1);
`ifdef I2C_CFG_READBACK_EN
                            rd_phase <= 1'b0;
`endif
                            state <= S_ISSUE;
                        end else begin
                            state <= S_FAIL;
                        end
                    end else begin
                        gcnt <= gcnt + GAP_W'(1);
                    end
                end
                S_FINISH: begin
                    cfg_done <= 1'b1;
                    cfg_busy <= 1'b0;
                    m_wr     <= 1'b0;
                    state    <= S_IDLE;
                end
                S_FAIL: begin
                    cfg_fail     <= 1'b1;
                    fail_idx     <= idx[IDX_W-1:0];
                    fail_timeout <= (outcome == OC_TIMEOUT);
                    cfg_busy     <= 1'b0;
                    m_wr         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomized bench for i2c_cfg_sequencer: ROM + I2C master model, checked against a per-entry attempt model.
module tb_i2c_cfg_sequencer;

    localparam int TD  = 16;
    localparam int IW  = 4;
    localparam int MR  = 3;
    localparam int GAP = 20;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [IW-1:0] tbl_addr;
    logic [23:0]   tbl_data;
    logic          m_start, m_wr;
    logic [23:0]   m_data;
    logic          m_busy, m_done, m_error;
    logic [7:0]    m_rdata;
    logic          cfg_busy, cfg_done, cfg_fail, fail_timeout;
    logic [IW-1:0] fail_idx;

    always #5 clk = ~clk;

    i2c_cfg_sequencer #(
        .TABLE_DEPTH(TD), .IDX_W(IW), .MAX_RETRY(MR),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_start(m_start), .m_wr(m_wr), .m_data(m_data),
        .m_busy(m_busy), .m_done(m_done), .m_error(m_error), .m_rdata(m_rdata),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail),
        .fail_idx(fail_idx), .fail_timeout(fail_timeout)
    );

    // Synchronous ROM
    logic [23:0] rom [0:TD-1];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Master model; response codes per transaction: 0 ACK, 1 NACK, 2 hang, 3 ACK with corrupted read byte
    int resp_q[$];
    int mph, mlat, mcur, rnext;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_error <= 1'b0; m_rdata <= '0; mph <= 0;
        end else begin
            case (mph)
                0: if (m_start) begin
                    rnext = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
                    mcur   <= rnext;
                    mlat   <= $urandom_range(1, 6);
                    m_busy <= 1'b1;
                    mph    <= 1;
                end
                1: if (!m_start) begin
                    m_busy <= 1'b0; mph <= 0;
                end else if (mcur != 2) begin
                    if (mlat > 0) mlat <= mlat - 1;
                    else begin
                        if (mcur == 1) m_error <= 1'b1; else m_done <= 1'b1;
                        m_rdata <= m_data[7:0] ^ ((mcur == 3) ? 8'h01 : 8'h00);
                        mph <= 2;
                    end
                end
                2: if (!m_start) begin
                    m_done <= 1'b0; m_error <= 1'b0; mph <= 3;
                end
                default: begin m_busy <= 1'b0; mph <= 0; end
            endcase
        end
    end

    // Monitor
    int          cyc = 0, hi_len = 0, done_cnt = 0;
    logic        st_prev = 1'b0;
    logic [24:0] obs_q[$];
    int          rise_q[$];
    int          len_q[$];
    always @(negedge clk) begin
        cyc++;
        if (m_start && !st_prev) begin
            obs_q.push_back({m_wr, m_data});
            rise_q.push_back(cyc);
            hi_len = 0;
        end
        if (m_start) hi_len++;
        if (!m_start && st_prev) len_q.push_back(hi_len);
        if (cfg_done) done_cnt++;
        st_prev = m_start;
    end

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model: each entry gets up to 1+MR attempts; attempt outcomes come from the response plan
    int          plan[$];
    logic [24:0] exp_q[$];
    bit          exp_fail, exp_to;
    int          exp_idx;

    function automatic int table_len();
        int n = 0;
        while (n < TD && rom[n] != 24'hFFFFFF) n++;
        return n;
    endfunction

    task automatic predict(input int n);
        int k, rty, r;
        bit bad;
        k = 0; exp_q.delete(); exp_fail = 0; exp_to = 0; exp_idx = 0;
        for (int e = 0; e < n; e++) begin
            rty = 0;
            forever begin
                r = (k < plan.size()) ? plan[k] : 0; k++;
                exp_q.push_back({1'b1, rom[e]});
                if (r == 2) begin exp_fail = 1; exp_to = 1; exp_idx = e; return; end
                bad = (r == 1);
`ifdef I2C_CFG_READBACK_EN
                if (!bad) begin
                    r = (k < plan.size()) ? plan[k] : 0; k++;
                    exp_q.push_back({1'b0, rom[e]});
                    if (r == 2) begin exp_fail = 1; exp_to = 1; exp_idx = e; return; end
                    bad = (r != 0);
                end
`endif
                if (!bad) break;
                if (rty == MR) begin exp_fail = 1; exp_idx = e; return; end
                rty++;
            end
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); rise_q.delete(); len_q.delete(); done_cnt = 0;
    endtask

    task automatic run_case(input string name, input bit hold_go);
        int  lim, nobs;
        bit  gap_ok;
        predict(table_len());
        resp_q = plan;
        @(negedge clk);
        clear_obs();
        go = 1'b1;
        @(negedge clk);
        check({name, ":busy"}, 32'(cfg_busy), 1);
        if (!hold_go) go = 1'b0;
        lim = 0;
        while (cfg_busy && lim < 30000) begin @(negedge clk); lim++; end
        check({name, ":end"}, 32'(cfg_busy), 0);
        repeat (3) @(negedge clk);
        check({name, ":n_start"}, obs_q.size(), exp_q.size());
        nobs = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nobs; i++)
            check($sformatf("%s:xfer%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
        check({name, ":done_cnt"}, done_cnt, exp_fail ? 0 : 1);
        check({name, ":fail"}, 32'(cfg_fail), 32'(exp_fail));
        if (exp_fail) begin
            check({name, ":fail_idx"}, 32'(fail_idx), exp_idx);
            check({name, ":fail_to"}, 32'(fail_timeout), 32'(exp_to));
        end
        if (exp_fail && exp_to)
            check({name, ":to_len"}, (len_q.size() > 0) ? len_q[len_q.size()-1] : 0, TO);
        check({name, ":start_low"}, 32'(m_start), 0);
        if (rise_q.size() >= 2) begin
            gap_ok = 1;
            for (int i = 1; i < rise_q.size(); i++)
                if (rise_q[i] - rise_q[i-1] < GAP) gap_ok = 0;
            check({name, ":gap"}, 32'(gap_ok), 1);
        end
        if (hold_go) begin
            repeat (30) @(negedge clk);
            check({name, ":no_retrig"}, 32'(cfg_busy), 0);
            go = 1'b0;
        end
        resp_q.delete();
    endtask

    task automatic load_table3(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        for (int i = 0; i < TD; i++) rom[i] = 24'hFFFFFF;
        rom[0] = a; rom[1] = b; rom[2] = c;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n, lim, r;
        logic [23:0] v;
        reset = 1'b1; go = 1'b0;
        for (int i = 0; i < TD; i++) rom[i] = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        check("rst:ctl", 32'({m_start, m_wr, cfg_busy, cfg_done, cfg_fail, fail_timeout}), 0);
        check("rst:data", 32'(m_data), 0);
        check("rst:idx", 32'({tbl_addr, fail_idx}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        load_table3(24'h4201AA, 24'h4202BB, 24'hFFFFFF);
        plan = '{};
        run_case("all_ack", 0);

        plan = '{0, 1, 1, 0};
        run_case("retry_ok", 0);

        load_table3(24'h4201AA, 24'h4202BB, 24'h4203CC);
        plan = '{0, 0, 1, 1, 1, 1};
`ifdef I2C_CFG_READBACK_EN
        plan = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        run_case("nack_fail", 0);

        plan = '{2};
        run_case("timeout", 0);

        // Reset while entry 1 is waiting on a hung master
        load_table3(24'h4201AA, 24'h4202BB, 24'hFFFFFF);
        plan = '{0, 2};
`ifdef I2C_CFG_READBACK_EN
        plan = '{0, 0, 2};
`endif
        resp_q = plan;
        @(negedge clk);
        clear_obs();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        lim = 0;
        while (obs_q.size() < plan.size() && lim < 5000) begin @(negedge clk); lim++; end
        check("rst_mid:reach_wait", obs_q.size(), plan.size());
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid:start", 32'(m_start), 0);
        check("rst_mid:busy", 32'(cfg_busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        resp_q.delete();
        plan = '{};
        run_case("after_rst", 0);

        // Randomized tables and response plans
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, TD);
            for (int i = 0; i < TD; i++) begin
                v = 24'($urandom());
                if (v == 24'hFFFFFF) v = 24'h0;
                rom[i] = (i == n) ? 24'hFFFFFF : v;
            end
            plan.delete();
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 99);
                plan.push_back((r < 70) ? 0 : (r < 92) ? 1 : (r < 97) ? 3 : 2);
            end
            run_case($sformatf("rnd%0d", t), t == 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
